// File: rtl/register_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_pkg : shared sizing and constants for register_file_32 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package register_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [RF_DATA_WIDTH-1:0] rf_word_t;

  localparam rf_word_t RF_ZERO_WORD = '0;

endpackage
`default_nettype wire

// File: rtl/reg_word_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_word_32 : load-enabled word register, synchronous active-low clr |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_word_32
  import register_file_pkg::*;
#(
  parameter int WIDTH = RF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= WIDTH'(RF_ZERO_WORD);
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_32 : 2-read/1-write register file, registered reads,   |
// | word 0 hardwired to zero. Option: REGISTER_FILE_BYPASS_EN forwards   |
// | same-cycle write data to a matching read port. Revision: 1.0         |
// +----------------------------------------------------------------------+
module register_file_32
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] words [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rd1_next;
  logic [DATA_WIDTH-1:0] rd2_next;

  generate
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
      if (i == 0) begin : g_zero
        assign words[i] = DATA_WIDTH'(RF_ZERO_WORD);
      end else begin : g_reg
        reg_word_32 #(
          .WIDTH(DATA_WIDTH)
        ) u_word (
          .clk  (CLK),
          .rst_n(RESET),
          .load (WRITE && (ADDR_W == ADDR_WIDTH'(i))),
          .d    (DATA_W),
          .q    (words[i])
        );
      end
    end
  endgenerate

`ifdef REGISTER_FILE_BYPASS_EN
  // Index 0 is excluded so the zero word can never be overridden.
  always_comb begin
    rd1_next = words[ADDR_R1];
    rd2_next = words[ADDR_R2];
    if (WRITE && (ADDR_W == ADDR_R1) && (ADDR_R1 != '0)) begin
      rd1_next = DATA_W;
    end
    if (WRITE && (ADDR_W == ADDR_R2) && (ADDR_R2 != '0)) begin
      rd2_next = DATA_W;
    end
  end
`else
  assign rd1_next = words[ADDR_R1];
  assign rd2_next = words[ADDR_R2];
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      DATA_R1  <= DATA_WIDTH'(RF_ZERO_WORD);
      DATA_R2  <= DATA_WIDTH'(RF_ZERO_WORD);
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= READ;
      if (READ) begin
        DATA_R1 <= rd1_next;
        DATA_R2 <= rd2_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_register_file_32 : directed + random bench with expected-value    |
// | queue and a behavioural memory model. Revision: 1.0                  |
// +----------------------------------------------------------------------+
module tb_register_file_32;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  aw;
  logic [31:0] dw;
  logic [31:0] q1;
  logic [31:0] q2;
  logic        vld;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];
  logic [31:0] last1;
  logic [31:0] last2;
  logic [63:0] exp_q [$];

  register_file_32 dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .READ    (rd),
    .WRITE   (wr),
    .ADDR_R1 (a1),
    .ADDR_R2 (a2),
    .ADDR_W  (aw),
    .DATA_W  (dw),
    .DATA_R1 (q1),
    .DATA_R2 (q2),
    .RD_VALID(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (w && (wa == ra)) return wd;
`endif
    return mem[ra];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, update the model, then check outputs just after the edge.
  task automatic cycle(input logic r, input logic rdv, input logic wrv,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [4:0] wa, input logic [31:0] wd, input string tag);
    logic [63:0] e;
    logic        exp_v;
    rst_n = r; rd = rdv; wr = wrv; a1 = ra1; a2 = ra2; aw = wa; dw = wd;
    if (!r) begin
      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
      last1 = 32'h0;
      last2 = 32'h0;
      exp_v = 1'b0;
    end else begin
      exp_v = rdv;
      if (rdv) exp_q.push_back({model_read(ra1, wrv, wa, wd), model_read(ra2, wrv, wa, wd)});
      if (wrv && (wa != 5'd0)) mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    if (exp_v) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL %s scoreboard empty got=%0d exp=1", tag, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last1 = e[63:32];
        last2 = e[31:0];
      end
    end
    check({tag, "_r1"}, q1, last1);
    check({tag, "_r2"}, q2, last2);
    check({tag, "_vld"}, {31'h0, vld}, {31'h0, exp_v});
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; a1 = '0; a2 = '0; aw = '0; dw = '0;
    last1 = '0; last2 = '0;
    for (int k = 0; k < 32; k++) mem[k] = 32'h0;

    cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, "reset");
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 5'd31, 5'd0, 32'h0, "rst_read");

    cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, "wr5");
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0, "rd5");

    cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, "wr0");
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, "rd0");
    cycle(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678, "rdwr0");

    cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1, "wr7");
    cycle(1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h2, "rdwr7");
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0, "rd7");

    cycle(1'b1, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0, "hold_rd");
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 32'h0, "hold");
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0, "rd5_new");

    cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h55, "wr9");
    cycle(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'hA5, "rst_mid");
    cycle(1'b1, 1'b1, 1'b0, 5'd9, 5'd7, 5'd0, 32'h0, "rd9");

    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, "rand");
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 5'(k), 5'(31 - k), 5'(k + 1), 32'hC0DE0000 + 32'(k), "b2b");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_32.md
REGISTER_FILE_32 -- requirements
Module: register_file_32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of each stored word and each data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the index width giving 2**ADDR_WIDTH words.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RESET, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port READ, input, 1, read request strobe.
REQ-006 SHALL have port WRITE, input, 1, write request strobe.
REQ-007 SHALL have port ADDR_R1, input, ADDR_WIDTH, read port 1 index.
REQ-008 SHALL have port ADDR_R2, input, ADDR_WIDTH, read port 2 index.
REQ-009 SHALL have port ADDR_W, input, ADDR_WIDTH, write index.
REQ-010 SHALL have port DATA_W, input, DATA_WIDTH, write data.
REQ-011 SHALL have port DATA_R1, output, DATA_WIDTH, registered read data for port 1.
REQ-012 SHALL have port DATA_R2, output, DATA_WIDTH, registered read data for port 2.
REQ-013 SHALL have port RD_VALID, output, 1, which is high for exactly the cycle in which DATA_R1/DATA_R2 first present a new read result.

Function
REQ-014 SHALL write DATA_W into word ADDR_W on a rising edge when RESET=1 and WRITE=1.
REQ-015 SHALL ignore writes to index 0; word 0 SHALL always read as 0.
REQ-016 SHALL, on a rising edge with RESET=1 and READ=1, capture word[ADDR_R1] into DATA_R1 and word[ADDR_R2] into DATA_R2; read latency is one cycle.
REQ-017 SHALL set RD_VALID=1 the cycle after an accepted read and RD_VALID=0 otherwise; back-to-back reads SHALL keep RD_VALID high every cycle.
REQ-018 SHALL hold DATA_R1/DATA_R2 at their last captured values while READ=0.
REQ-019 SHALL permit READ and WRITE in the same cycle; both SHALL be accepted.
REQ-020 SHALL, for a same-cycle read and write to the same nonzero index without bypass, return the pre-write (old) value.
REQ-021 SHALL allow ADDR_R1=ADDR_R2; both outputs SHALL then carry the identical value.
REQ-022 SHALL update the register state only on the clock edge; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 SHALL, on a rising edge with RESET=0, clear every word to 0, set DATA_R1=DATA_R2=0 and set RD_VALID=0.
REQ-024 SHALL give RESET priority over READ and WRITE; a read or write presented during reset SHALL be discarded.
REQ-025 SHALL accept the first read or write on the first edge with RESET=1.

Configuration
REQ-026 SHALL, when macro REGISTER_FILE_BYPASS_EN is defined, forward DATA_W to a read port on a same-cycle read and write to the same nonzero index, so that the port returns the new value.
REQ-027 SHALL, when REGISTER_FILE_BYPASS_EN is undefined, behave as REQ-020 with no forwarding logic present.
REQ-028 SHALL never forward into index 0 in either configuration.

Structure
REQ-029 SHALL take DATA_WIDTH, ADDR_WIDTH and the zero-word constant from shared package register_file_pkg.
REQ-030 SHALL build each storage word from one sub-module, reg_word_32: a load-enabled word register with synchronous active-low clear.

Verification
REQ-031 SHALL cover reset: RESET=0 for 1 edge, then READ with ADDR_R1=3 and ADDR_R2=31 -> DATA_R1=0, DATA_R2=0, RD_VALID=1 the next cycle.
REQ-032 SHALL cover write then read: write 'hDEADBEEF to index 5, then read R1=5, R2=5 -> both outputs 'hDEADBEEF one cycle after READ.
REQ-033 SHALL cover word 0: write 'hFFFFFFFF to index 0, then read R1=0 -> DATA_R1=0.
REQ-034 SHALL cover same-cycle read and write: index 7 holds 'h1, then write 'h2 and read 7 in the same cycle -> 'h1 without bypass, 'h2 with REGISTER_FILE_BYPASS_EN; a following read -> 'h2.
REQ-035 SHALL cover hold: read index 5 ('hDEADBEEF), then READ=0 for 3 cycles while index 5 is rewritten with 'h0 -> DATA_R1 stays 'hDEADBEEF and RD_VALID=0.
REQ-036 SHALL cover reset mid-operation: READ=1, WRITE=1 with index 9 = 'hA5 in the same cycle as RESET=0 -> outputs 0, RD_VALID=0, and a later read of index 9 -> 0.
